// File: rtl/s_term_switch_matrix_cfg.sv
// South-edge termination switch matrix with serially loaded per-group modes.
// Mode changes pass through a one-cycle drain that holds every output low.

module s_term_grp #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         drain_i,
  input  logic [1:0]   mode_i,
  input  logic [W-1:0] s_i,
  output logic [W-1:0] n_o
);

  logic [W-1:0] rev;
  logic [W-1:0] pipe_d;
  logic [W-1:0] pipe_q;

  // Bit-reverse the incoming wires
  always_comb begin
    rev = '0;
    for (int i = 0; i < W; i++) begin
      rev[i] = s_i[W-1-i];
    end
  end

  // Pipe is flushed while draining so stale data never survives a mode change
  always_comb begin
    pipe_d = drain_i ? '0 : rev;
  end

  // Registered-reverse pipeline stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // Output select by group mode
  always_comb begin
    n_o = '0;
    if (!drain_i) begin
      unique case (mode_i)
        2'b00: n_o = rev;
        2'b01: n_o = s_i;
        2'b10: n_o = pipe_q;
        2'b11: n_o = '0;
        default: n_o = '0;
      endcase
    end
  end

endmodule

module s_term_switch_matrix_cfg #(
  parameter int W1           = 4,
  parameter int W2           = 8,
  parameter int W4           = 16,
  parameter int NoConfigBits = 8
) (
  input  logic                    UserCLK,
  input  logic                    RESET_N,
  input  logic [W1-1:0]           S1END,
  input  logic [W2-1:0]           S2MID,
  input  logic [W2-1:0]           S2END,
  input  logic [W4-1:0]           S4END,
  output logic [W1-1:0]           N1BEG,
  output logic [W2-1:0]           N2BEG,
  output logic [W2-1:0]           N2BEGb,
  output logic [W4-1:0]           N4BEG,
  input  logic                    cfg_sdi,
  input  logic                    cfg_shift,
  input  logic                    cfg_commit,
  output logic                    cfg_sdo,
  output logic                    cfg_busy,
  output logic [NoConfigBits-1:0] cfg_active
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [NoConfigBits-1:0] shadow_q;
  logic [NoConfigBits-1:0] shadow_d;
  logic [NoConfigBits-1:0] pending_q;
  logic [NoConfigBits-1:0] pending_d;
  logic [NoConfigBits-1:0] active_q;
  logic [NoConfigBits-1:0] active_d;

  logic drain;

  // Shadow shifts independently of the commit FSM
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_shift) begin
      shadow_d = {cfg_sdi, shadow_q[NoConfigBits-1:1]};
    end
  end

  // Commit FSM: capture pre-shift shadow, drain one cycle, then apply
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    active_d  = active_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_commit) begin
          pending_d = shadow_q;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        active_d = pending_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Configuration and FSM state registers
  always_ff @(posedge UserCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      pending_q <= '0;
      active_q  <= '0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      active_q  <= active_d;
    end
  end

  assign drain      = (state_q == DRAIN);
  assign cfg_busy   = drain;
  assign cfg_sdo    = shadow_q[0];
  assign cfg_active = active_q;

  s_term_grp #(.W(W1)) u_g1 (
    .clk_i   (UserCLK),
    .rst_ni  (RESET_N),
    .drain_i (drain),
    .mode_i  (active_q[1:0]),
    .s_i     (S1END),
    .n_o     (N1BEG)
  );

  s_term_grp #(.W(W2)) u_g2 (
    .clk_i   (UserCLK),
    .rst_ni  (RESET_N),
    .drain_i (drain),
    .mode_i  (active_q[3:2]),
    .s_i     (S2MID),
    .n_o     (N2BEG)
  );

  s_term_grp #(.W(W2)) u_g2b (
    .clk_i   (UserCLK),
    .rst_ni  (RESET_N),
    .drain_i (drain),
    .mode_i  (active_q[5:4]),
    .s_i     (S2END),
    .n_o     (N2BEGb)
  );

  s_term_grp #(.W(W4)) u_g4 (
    .clk_i   (UserCLK),
    .rst_ni  (RESET_N),
    .drain_i (drain),
    .mode_i  (active_q[7:6]),
    .s_i     (S4END),
    .n_o     (N4BEG)
  );

endmodule

// File: tb/tb_s_term_switch_matrix_cfg.sv
// Directed bench for the south termination switch matrix.
// Table vectors per config word plus hand sequences for commit corners.

module tb_s_term_switch_matrix_cfg;

  logic        UserCLK;
  logic        RESET_N;
  logic [3:0]  S1END;
  logic [7:0]  S2MID;
  logic [7:0]  S2END;
  logic [15:0] S4END;
  logic [3:0]  N1BEG;
  logic [7:0]  N2BEG;
  logic [7:0]  N2BEGb;
  logic [15:0] N4BEG;
  logic        cfg_sdi;
  logic        cfg_shift;
  logic        cfg_commit;
  logic        cfg_sdo;
  logic        cfg_busy;
  logic [7:0]  cfg_active;

  int nchecks = 0;
  int nerr    = 0;

  s_term_switch_matrix_cfg dut (
    .UserCLK    (UserCLK),
    .RESET_N    (RESET_N),
    .S1END      (S1END),
    .S2MID      (S2MID),
    .S2END      (S2END),
    .S4END      (S4END),
    .N1BEG      (N1BEG),
    .N2BEG      (N2BEG),
    .N2BEGb     (N2BEGb),
    .N4BEG      (N4BEG),
    .cfg_sdi    (cfg_sdi),
    .cfg_shift  (cfg_shift),
    .cfg_commit (cfg_commit),
    .cfg_sdo    (cfg_sdo),
    .cfg_busy   (cfg_busy),
    .cfg_active (cfg_active)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  typedef struct {
    logic [7:0]  cfg;
    logic [3:0]  s1;
    logic [7:0]  s2m;
    logic [7:0]  s2e;
    logic [15:0] s4;
    logic [3:0]  n1;
    logic [7:0]  n2;
    logic [7:0]  n2b;
    logic [15:0] n4;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic shift_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      cfg_sdi   = w[i];
      cfg_shift = 1'b1;
      step();
    end
    cfg_shift = 1'b0;
    cfg_sdi   = 1'b0;
  endtask

  task automatic commit(input logic [7:0] w);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    #1;
    chk("drain_busy", {15'd0, cfg_busy}, 16'd1);
    chk("drain_outs", {N1BEG, N2BEG} | N2BEGb | N4BEG, 16'd0);
    step();
    chk("post_busy", {15'd0, cfg_busy}, 16'd0);
    chk("post_active", {8'd0, cfg_active}, {8'd0, w});
  endtask

  initial begin
    vecs[0] = '{8'h00, 4'b0011, 8'h01, 8'h0F, 16'h0001,
                4'b1100, 8'h80, 8'hF0, 16'h8000};
    vecs[1] = '{8'h40, 4'b0001, 8'h03, 8'h10, 16'h1234,
                4'b1000, 8'hC0, 8'h08, 16'h1234};
    vecs[2] = '{8'h55, 4'hA, 8'h5C, 8'h81, 16'hBEEF,
                4'hA, 8'h5C, 8'h81, 16'hBEEF};
    vecs[3] = '{8'hAA, 4'b0010, 8'h01, 8'h12, 16'h00F1,
                4'b0100, 8'h80, 8'h48, 16'h8F00};
    vecs[4] = '{8'hFF, 4'hF, 8'hFF, 8'hFF, 16'hFFFF,
                4'h0, 8'h00, 8'h00, 16'h0000};
    vecs[5] = '{8'hE4, 4'b1000, 8'h3C, 8'h07, 16'hFFFF,
                4'b0001, 8'h3C, 8'hE0, 16'h0000};
    vecs[6] = '{8'h1B, 4'hF, 8'h80, 8'h69, 16'h0003,
                4'h0, 8'h01, 8'h69, 16'hC000};

    RESET_N    = 1'b0;
    cfg_sdi    = 1'b0;
    cfg_shift  = 1'b0;
    cfg_commit = 1'b0;
    S1END      = 4'b0011;
    S2MID      = 8'h00;
    S2END      = 8'h00;
    S4END      = 16'h0001;
    #2;
    chk("rst_n4", N4BEG, 16'h8000);
    chk("rst_n1", {12'd0, N1BEG}, 16'h000C);
    chk("rst_active", {8'd0, cfg_active}, 16'd0);
    chk("rst_busy", {15'd0, cfg_busy}, 16'd0);
    chk("rst_sdo", {15'd0, cfg_sdo}, 16'd0);
    step();
    step();
    RESET_N = 1'b1;
    step();

    for (int v = 0; v < 7; v++) begin
      shift_word(vecs[v].cfg);
      chk("shadow_noeffect", {8'd0, cfg_active},
          v == 0 ? 16'd0 : {8'd0, vecs[v-1].cfg});
      commit(vecs[v].cfg);
      S1END = vecs[v].s1;
      S2MID = vecs[v].s2m;
      S2END = vecs[v].s2e;
      S4END = vecs[v].s4;
      step();
      chk("vec_n1", {12'd0, N1BEG}, {12'd0, vecs[v].n1});
      chk("vec_n2", {8'd0, N2BEG}, {8'd0, vecs[v].n2});
      chk("vec_n2b", {8'd0, N2BEGb}, {8'd0, vecs[v].n2b});
      chk("vec_n4", N4BEG, vecs[v].n4);
    end

    // Registered mode latency on N2BEG
    S2MID = 8'hFF;
    shift_word(8'h08);
    commit(8'h08);
    S2MID = 8'h01;
    #1;
    chk("reg_first_zero", {8'd0, N2BEG}, 16'd0);
    step();
    chk("reg_one_late", {8'd0, N2BEG}, 16'h0080);
    S2MID = 8'h02;
    #1;
    chk("reg_holds", {8'd0, N2BEG}, 16'h0080);
    step();
    chk("reg_next", {8'd0, N2BEG}, 16'h0040);

    // Tie-off everything, sdo shows shadow[0]
    S1END = 4'hF;
    S2MID = 8'hFF;
    S2END = 8'hFF;
    S4END = 16'hFFFF;
    shift_word(8'hFF);
    chk("tie_sdo", {15'd0, cfg_sdo}, 16'd1);
    commit(8'hFF);
    step();
    chk("tie_outs", {N1BEG, N2BEG} | N2BEGb | N4BEG, 16'd0);

    // Shift and commit on the same edge, then ignored commit in drain
    shift_word(8'h01);
    cfg_sdi    = 1'b1;
    cfg_shift  = 1'b1;
    cfg_commit = 1'b1;
    step();
    cfg_shift = 1'b0;
    cfg_sdi   = 1'b0;
    chk("sc_busy1", {15'd0, cfg_busy}, 16'd1);
    chk("sc_sdo", {15'd0, cfg_sdo}, 16'd0);
    step();
    cfg_commit = 1'b0;
    chk("sc_busy_done", {15'd0, cfg_busy}, 16'd0);
    chk("sc_active", {8'd0, cfg_active}, 16'h0001);
    step();
    chk("sc_no_second", {15'd0, cfg_busy}, 16'd0);
    commit(8'h80);

    // Reset in the middle of a drain
    S1END = 4'b0011;
    S4END = 16'h0001;
    S2MID = 8'h01;
    S2END = 8'h0F;
    shift_word(8'h55);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    chk("rd_busy", {15'd0, cfg_busy}, 16'd1);
    RESET_N = 1'b0;
    #1;
    chk("rd_busy_clr", {15'd0, cfg_busy}, 16'd0);
    chk("rd_active", {8'd0, cfg_active}, 16'd0);
    chk("rd_n4", N4BEG, 16'h8000);
    chk("rd_n1", {12'd0, N1BEG}, 16'h000C);
    chk("rd_n2", {8'd0, N2BEG}, 16'h0080);
    chk("rd_n2b", {8'd0, N2BEGb}, 16'h00F0);
    step();
    RESET_N = 1'b1;
    step();
    chk("rd_stay", {8'd0, cfg_active}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
